// File: rtl/axi_slv_arbiter_pkg.sv
// rtl/axi_slv_arbiter_pkg.sv - shared frame layout and arbiter state encodings
// Purpose: frame field offsets, frame type and FSM state encodings shared by the
//          arbiter, its output register and the AXI channel stages.
// Ports:   none (package).
package axi_slv_arbiter_pkg;

  localparam int FRAME_WIDTH = 97;

  localparam int LEN_MSB  = 96;
  localparam int LEN_LSB  = 89;
  localparam int EOF_BIT  = 88;
  localparam int SOF_BIT  = 87;
  localparam int WR_BIT   = 86;
  localparam int DATA_MSB = 85;
  localparam int DATA_LSB = 22;
  localparam int ADDR_MSB = 21;
  localparam int ADDR_LSB = 0;

  typedef logic [FRAME_WIDTH-1:0] frame_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WGNT = 2'd1,
    RGNT = 2'd2
  } arb_state_e;

endpackage

// File: rtl/axi_slv_arbiter_if.sv
// rtl/axi_slv_arbiter_if.sv - frame handshake bundle between AXI stages, arbiter and memory controller
// Purpose: groups the write/read frame inputs, the memory-controller frame output
//          and the sticky error flag.
// Ports:   slave  - arbiter side (consumes w/r frames, produces arb2mc frame + error)
//          master - environment side (produces w/r frames, consumes arb2mc frame)
interface axi_slv_arbiter_if;
  import axi_slv_arbiter_pkg::*;

  logic   axi2arb_wframe_valid;
  logic   axi2arb_wframe_ready;
  frame_t axi2arb_wframe_data;

  logic   axi2arb_rframe_valid;
  logic   axi2arb_rframe_ready;
  frame_t axi2arb_rframe_data;

  logic   arb2mc_frame_valid;
  logic   arb2mc_frame_ready;
  frame_t arb2mc_frame_data;

  logic   arb_frame_err;

  modport slave (
    input  axi2arb_wframe_valid, axi2arb_wframe_data,
    output axi2arb_wframe_ready,
    input  axi2arb_rframe_valid, axi2arb_rframe_data,
    output axi2arb_rframe_ready,
    output arb2mc_frame_valid, arb2mc_frame_data,
    input  arb2mc_frame_ready,
    output arb_frame_err
  );

  modport master (
    output axi2arb_wframe_valid, axi2arb_wframe_data,
    input  axi2arb_wframe_ready,
    output axi2arb_rframe_valid, axi2arb_rframe_data,
    input  axi2arb_rframe_ready,
    input  arb2mc_frame_valid, arb2mc_frame_data,
    output arb2mc_frame_ready,
    input  arb_frame_err
  );

endinterface

// File: rtl/axi_frame_reg.sv
// rtl/axi_frame_reg.sv - one-entry valid/ready pipeline register
// Purpose: registers one beat; accepts a new beat whenever empty or being drained
//          in the same cycle, so full throughput is kept with a single entry.
// Ports:   clk, rst_n                      - clock, async active-low reset
//          in_valid/in_ready/in_data       - upstream beat
//          out_valid/out_ready/out_data    - downstream beat (registered)
module axi_frame_reg
  import axi_slv_arbiter_pkg::*;
#(
  parameter int WIDTH = FRAME_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  // Ready looks only at our own state and the downstream ready, never at in_data.
  assign in_ready  = !valid_q || out_ready;
  assign out_valid = valid_q;
  assign out_data  = data_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (in_valid && in_ready) begin
      // Load wins over unload: a simultaneous drain and refill stays valid.
      valid_d = 1'b1;
      data_d  = in_data;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/axi_slv_arbiter.sv
// rtl/axi_slv_arbiter.sv - round-robin frame arbiter from AXI write/read stages to the memory controller
// Purpose: grants one source per frame (first granted beat through the eof beat),
//          alternating between write and read on contention, and forwards granted
//          beats unmodified through a one-entry output register. Flags frames that
//          run past MAX_BEATS without eof.
// Ports:   clk, rst_n - clock, async active-low reset
//          bus        - axi_slv_arbiter_if.slave: w/r frame inputs, arb2mc output, error flag
module axi_slv_arbiter
  import axi_slv_arbiter_pkg::*;
#(
  parameter int MAX_BEATS = 64,
  parameter bit RD_FIRST  = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  axi_slv_arbiter_if.slave   bus
);

  localparam logic [6:0] MAX_CNT = 7'(MAX_BEATS);
  // last_rd_q names the source granted last; on contention the other one wins,
  // so the reset value is the opposite of the source that should go first.
  localparam logic LAST_RD_RST = !RD_FIRST;

  arb_state_e state_q, state_d;
  logic       last_rd_q, last_rd_d;
  logic [6:0] cnt_q, cnt_d;
  logic       err_q, err_d;

  logic   reg_in_ready;
  logic   reg_in_valid;
  logic   w_hs, r_hs, hs;
  frame_t sel_data;

  assign bus.axi2arb_wframe_ready = (state_q == WGNT) && reg_in_ready;
  assign bus.axi2arb_rframe_ready = (state_q == RGNT) && reg_in_ready;

  assign w_hs = bus.axi2arb_wframe_valid && bus.axi2arb_wframe_ready;
  assign r_hs = bus.axi2arb_rframe_valid && bus.axi2arb_rframe_ready;
  assign hs   = w_hs || r_hs;

  assign reg_in_valid = ((state_q == WGNT) && bus.axi2arb_wframe_valid) ||
                        ((state_q == RGNT) && bus.axi2arb_rframe_valid);
  assign sel_data     = (state_q == RGNT) ? bus.axi2arb_rframe_data
                                          : bus.axi2arb_wframe_data;

  assign bus.arb_frame_err = err_q;

  always_comb begin
    state_d   = state_q;
    last_rd_d = last_rd_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    case (state_q)
      IDLE: begin
        // Readies are 0 here, so every frame sees at least one idle bubble.
        cnt_d = '0;
        if (bus.axi2arb_wframe_valid && bus.axi2arb_rframe_valid) begin
          state_d = last_rd_q ? WGNT : RGNT;
        end else if (bus.axi2arb_wframe_valid) begin
          state_d = WGNT;
        end else if (bus.axi2arb_rframe_valid) begin
          state_d = RGNT;
        end
      end
      WGNT, RGNT: begin
        if (hs) begin
          cnt_d = cnt_q + 7'd1;
          // Error only; the grant is kept until the source finally sends eof.
          if ((cnt_q == MAX_CNT) && !sel_data[EOF_BIT]) begin
            err_d = 1'b1;
          end
          if (sel_data[EOF_BIT]) begin
            state_d   = IDLE;
            last_rd_d = (state_q == RGNT);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      last_rd_q <= LAST_RD_RST;
      cnt_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_rd_q <= last_rd_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
    end
  end

  axi_frame_reg #(
    .WIDTH(FRAME_WIDTH)
  ) u_out_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (reg_in_valid),
    .in_ready (reg_in_ready),
    .in_data  (sel_data),
    .out_valid(bus.arb2mc_frame_valid),
    .out_ready(bus.arb2mc_frame_ready),
    .out_data (bus.arb2mc_frame_data)
  );

endmodule
